// File: rtl/spi_slave_cmd_handler_if.sv
// Word-level handshake between the SPI slave shift engine and the command handler.
interface spi_slave_cmd_handler_if;
  logic        cs_active;
  logic        rx_valid;
  logic [15:0] rx_word;
  logic [15:0] tx_data;
  logic        tx_load;
  logic        tx_oe;

  modport master (
    output cs_active, rx_valid, rx_word,
    input  tx_data, tx_load, tx_oe
  );

  modport slave (
    input  cs_active, rx_valid, rx_word,
    output tx_data, tx_load, tx_oe
  );
endinterface

// File: rtl/spi_slave_cmd_handler.sv
// Slave-side decoder for 32-bit command/data frames with a 256x16 register file.
// Decodes the command word, commits writes, loads read data back for word 1.
//
// state       | meaning
// S_IDLE      | waiting for a command word inside an active frame
// S_DECODE    | command latched, applying accept rules
// S_RD_LOAD   | read data handed to the shift engine, MISO driven
// S_WAIT_DATA | waiting for word 1 (write data or read dummy)
// S_WRITE     | write committed this cycle
// S_DROP      | frame finished or rejected, waiting for CS to release
module spi_slave_cmd_handler #(
  parameter logic [2:0]  MY_ID     = 3'd0,
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_slave_cmd_handler_if.slave  bus,
  output logic                    wr_pulse,
  output logic                    err_pulse,
  input  logic [7:0]              dbg_addr,
  output logic [15:0]             dbg_data,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_RD_LOAD,
    S_WAIT_DATA,
    S_WRITE,
    S_DROP
  } state_t;

  state_t      state;
  logic [15:0] cmd_q;
  logic [15:0] mem [256];

  // Reserved bits set, or a read addressed globally (the slaves would fight on MISO).
  function automatic logic is_malformed(input logic [15:0] w);
    return (w[15:14] != 2'b00) || w[0] || (w[2] && w[1]);
  endfunction

  logic       id_match;
  logic [7:0] cmd_addr;
  logic       cmd_read;

  assign id_match = (cmd_q[13:11] == MY_ID);
  assign cmd_addr = cmd_q[10:3];
  assign cmd_read = cmd_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_q       <= 16'h0000;
      bus.tx_data <= 16'h0000;
      bus.tx_load <= 1'b0;
      bus.tx_oe   <= 1'b0;
      wr_pulse    <= 1'b0;
      err_pulse   <= 1'b0;
      frame_cnt   <= 16'h0000;
      dbg_data    <= RESET_VAL;
      for (int i = 0; i < 256; i++) mem[i] <= RESET_VAL;
    end else begin
      bus.tx_load <= 1'b0;
      wr_pulse    <= 1'b0;
      err_pulse   <= 1'b0;
      // Sampled before any write this cycle, so a same-address write shows one cycle later.
      dbg_data    <= mem[dbg_addr];

      case (state)
        S_IDLE: begin
          bus.tx_oe <= 1'b0;
          if (bus.cs_active && bus.rx_valid) begin
            cmd_q     <= bus.rx_word;
            err_pulse <= is_malformed(bus.rx_word);
            state     <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (!bus.cs_active) begin
            state <= S_IDLE;
          end else if (is_malformed(cmd_q) || !id_match) begin
            state <= S_DROP;
          end else begin
            frame_cnt <= frame_cnt + 16'd1;
            if (cmd_read) begin
              bus.tx_data <= mem[cmd_addr];
              bus.tx_load <= 1'b1;
              bus.tx_oe   <= 1'b1;
              state       <= S_RD_LOAD;
            end else begin
              state <= S_WAIT_DATA;
            end
          end
        end

        S_RD_LOAD: begin
          if (!bus.cs_active) begin
            err_pulse <= 1'b1;
            bus.tx_oe <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_WAIT_DATA;
          end
        end

        S_WAIT_DATA: begin
          if (!bus.cs_active) begin
            err_pulse <= 1'b1;
            bus.tx_oe <= 1'b0;
            state     <= S_IDLE;
          end else if (bus.rx_valid) begin
            if (cmd_read) begin
              state <= S_DROP;
            end else begin
              mem[cmd_addr] <= bus.rx_word;
              wr_pulse      <= 1'b1;
              state         <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          state <= bus.cs_active ? S_DROP : S_IDLE;
        end

        S_DROP: begin
          if (!bus.cs_active) begin
            bus.tx_oe <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          bus.tx_oe <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_slave_cmd_handler.md
# spi_slave_cmd_handler

Slave-side command decoder and register file: the responder for the 32-bit command/data frames issued by the SPI master control FSM. It sits behind the SPI slave shift engine and consumes received 16-bit words. It decodes the command word (ID, address, global, read/write), performs writes into a 256x16 register file, and loads read data back into the shift engine in time for the second word of the frame. It also drives MISO output-enable, so several slaves can share one MISO line.

## Interface
- MY_ID, 3'd0, slave ID this instance answers to
- RESET_VAL, 16'h0000, reset contents of every register-file entry
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cs_active  in  1  frame in progress (synchronized, inverted CS_n from shift engine)
- rx_valid  in  1  one-cycle pulse: rx_word holds a complete received word
- rx_word  in  16  received word, MSB first as shifted
- tx_data  out  16  word for the shift engine to send next
- tx_load  out  1  one-cycle pulse: shift engine captures tx_data
- tx_oe  out  1  MISO output enable for this slave
- wr_pulse  out  1  one-cycle pulse when a register-file write commits
- err_pulse  out  1  one-cycle pulse on malformed command or aborted frame
- dbg_addr  in  8  local read address (LED/display path)
- dbg_data  out  16  registered read of mem[dbg_addr]
- frame_cnt  out  16  count of accepted (decoded, ID-matched) commands, wraps

## Operation
- Command word: [15:14] reserved 2'b00, [13:11] id, [10:3] addr, [2] global, [1] rw (1=read, 0=write), [0] reserved 0.
- Frame: word 0 is the command. Word 1 is the write data, or a dummy word during a read while the slave returns mem[addr].
- Accept rules:
  - Write is accepted if id==MY_ID; the global bit does not change acceptance, because the master iterates all IDs.
  - Read is accepted if id==MY_ID and global==0.
  - Read with global=1 is malformed.
  - A reserved-bit violation is malformed.
  - An id mismatch is not an error: the slave drops the frame silently.
- States:
  - S_IDLE: wait for rx_valid while cs_active=1. Latch the word and go to S_DECODE.
  - S_DECODE: evaluate the accept rules.
    - Malformed: err_pulse, go to S_DROP.
    - Mismatch: go to S_DROP.
    - Accepted read: go to S_RD_LOAD.
    - Accepted write: go to S_WAIT_DATA.
    - Accepted read or write increments frame_cnt.
  - S_RD_LOAD: tx_data<=mem[addr], tx_load=1, tx_oe<=1, go to S_WAIT_DATA.
  - S_WAIT_DATA: on rx_valid, go to S_WRITE for a write or S_DROP for a read.
  - S_WRITE: mem[addr]<=data word, wr_pulse=1, go to S_DROP.
  - S_DROP: ignore further rx_valid. On cs_active=0, go to S_IDLE.
- Abort: cs_active=0 in any state other than S_IDLE/S_DROP returns to S_IDLE. No write is performed, tx_oe<=0, and err_pulse fires if the state was S_WAIT_DATA or S_RD_LOAD.
- An rx_valid in the same cycle as cs_active=0 is discarded.
- tx_oe clears in the cycle after cs_active falls, and in every state except S_RD_LOAD/S_WAIT_DATA/S_DROP-after-read.
- dbg_data is read-before-write: if S_WRITE targets dbg_addr in the same cycle, dbg_data shows the old value for that cycle and the new value the following cycle.

## Timing
- Reset values:
  - state S_IDLE
  - tx_data 16'h0000
  - tx_load, tx_oe, wr_pulse, err_pulse all 0
  - frame_cnt 0
  - dbg_data RESET_VAL
  - all mem entries RESET_VAL
- Command rx_valid at cycle T:
  - S_DECODE at T+1.
  - For a read, tx_load and valid tx_data at T+2.
  - The shift engine guarantees at least 4 clk between word-0 rx_valid and the first SCLK edge of word 1.
- Write data rx_valid at cycle D: mem updated and wr_pulse at D+1 (S_WRITE); readable via dbg_data at D+2.
- Single-cycle pulses only; outputs are registered.
- frame_cnt wraps from 16'hFFFF to 0.

## Test plan
- Write then read, MY_ID=3:
  - Write frame cmd {00,3'd3,8'h5A,0,0,0} = 0x1AD0, data 0xBEEF -> wr_pulse once, dbg_addr=0x5A shows 0xBEEF.
  - Then read cmd 0x1AD2 -> tx_load at T+2 with tx_data=0xBEEF, tx_oe=1 until cs_active falls.
- ID mismatch: same frames with id=4 -> no wr_pulse, no tx_load, tx_oe stays 0, err_pulse 0, frame_cnt unchanged.
- Global write loop:
  - Eight frames ids 0..7, addr 0x10, global=1, data 0x1234 -> exactly one wr_pulse (id 3 frame), mem[0x10]=0x1234.
  - Global read 0x1886 -> err_pulse, no tx_load.
- Malformed: cmd 0xDAD0 (reserved bits 11) -> err_pulse at T+1, following data word ignored, memory unchanged.
- Abort: accepted write command, then cs_active drops before the data word -> err_pulse, no write, back in S_IDLE. The next valid frame completes normally.
- Reset mid-frame: assert rst during S_WAIT_DATA of a read -> tx_oe=0, frame_cnt=0, mem[0x5A]=RESET_VAL immediately (asynchronous).
